// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : stopwatch_ctrl                                                    |
// | Brief  : Run/pause/adjust/clear sequencer issuing single-cycle increment   |
// |          and clear strobes to the BCD time counter, plus blink selects.    |
// | Option : STOPWATCH_CTRL_LAP_EN adds lap_btn / disp_hold (display freeze).  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module stopwatch_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int ADJ_HOLD_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       pause_btn,
    input  logic       clear_btn,
    input  logic       sel,
    input  logic       adj,
    input  logic       sec_wrap,
`ifdef STOPWATCH_CTRL_LAP_EN
    input  logic       lap_btn,
    output logic       disp_hold,
`endif
    output logic       sec_inc,
    output logic       min_inc,
    output logic       cnt_clr,
    output logic       blink_min,
    output logic       blink_sec,
    output logic       running,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_PAUSED  = 3'd1,
        ST_ADJ_MIN = 3'd2,
        ST_ADJ_SEC = 3'd3,
        ST_CLEAR   = 3'd4
    } state_t;

    localparam int c_hold_w = (ADJ_HOLD_TICKS < 1) ? 1 : $clog2(ADJ_HOLD_TICKS + 1);
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(ADJ_HOLD_TICKS);

    logic [SYNC_STAGES-1:0] r_sel_sync;
    logic [SYNC_STAGES-1:0] r_adj_sync;
    logic                   r_pause_d;
    logic                   r_clear_d;
    logic [c_hold_w-1:0]    r_hold;
    state_t                 r_state;

    state_t w_next;
    logic   w_sel_s;
    logic   w_adj_s;
    logic   w_pause_rise;
    logic   w_clear_rise;
    logic   w_in_adj;
    logic   w_adj_tick;
    logic   w_strobe_ok;
    logic   w_sec_req;
    logic   w_min_req;

    // Switch synchronisers and button edge history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sel_sync <= '0;
            r_adj_sync <= '0;
            r_pause_d  <= 1'b0;
            r_clear_d  <= 1'b0;
        end else begin
            r_sel_sync <= {r_sel_sync[SYNC_STAGES-2:0], sel};
            r_adj_sync <= {r_adj_sync[SYNC_STAGES-2:0], adj};
            r_pause_d  <= pause_btn;
            r_clear_d  <= clear_btn;
        end
    end

    assign w_sel_s      = r_sel_sync[SYNC_STAGES-1];
    assign w_adj_s      = r_adj_sync[SYNC_STAGES-1];
    assign w_pause_rise = pause_btn & ~r_pause_d;
    assign w_clear_rise = clear_btn & ~r_clear_d;
    assign w_in_adj     = (r_state == ST_ADJ_MIN) || (r_state == ST_ADJ_SEC);
    assign w_adj_tick   = tick_2hz | (tick_1hz & (r_hold == c_hold_max));
    // A strobe is never issued directly behind another one
    assign w_strobe_ok  = ~(sec_inc | min_inc);

    always_comb begin
        w_next    = r_state;
        w_sec_req = 1'b0;
        w_min_req = 1'b0;
        if (w_clear_rise) begin
            w_next = ST_CLEAR;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    w_next = ST_PAUSED;
                end
                ST_RUN: begin
                    if (w_adj_s) begin
                        w_next = w_sel_s ? ST_ADJ_SEC : ST_ADJ_MIN;
                    end else if (w_pause_rise) begin
                        w_next = ST_PAUSED;
                    end else if (tick_1hz && w_strobe_ok) begin
                        w_sec_req = 1'b1;
                        w_min_req = sec_wrap;
                    end
                end
                ST_PAUSED: begin
                    if (w_adj_s) begin
                        w_next = w_sel_s ? ST_ADJ_SEC : ST_ADJ_MIN;
                    end else if (w_pause_rise) begin
                        w_next = ST_RUN;
                    end
                end
                ST_ADJ_MIN: begin
                    if (!w_adj_s) begin
                        w_next = ST_PAUSED;
                    end else if (w_sel_s) begin
                        w_next = ST_ADJ_SEC;
                    end else if (w_adj_tick && w_strobe_ok) begin
                        w_min_req = 1'b1;
                    end
                end
                ST_ADJ_SEC: begin
                    // No carry into minutes while adjusting seconds
                    if (!w_adj_s) begin
                        w_next = ST_PAUSED;
                    end else if (!w_sel_s) begin
                        w_next = ST_ADJ_MIN;
                    end else if (w_adj_tick && w_strobe_ok) begin
                        w_sec_req = 1'b1;
                    end
                end
                default: begin
                    w_next = ST_PAUSED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_PAUSED;
            r_hold    <= '0;
            sec_inc   <= 1'b0;
            min_inc   <= 1'b0;
            cnt_clr   <= 1'b0;
            running   <= 1'b0;
            blink_min <= 1'b0;
            blink_sec <= 1'b0;
        end else begin
            r_state   <= w_next;
            sec_inc   <= w_sec_req;
            min_inc   <= w_min_req;
            cnt_clr   <= (w_next == ST_CLEAR);
            running   <= (w_next == ST_RUN);
            blink_min <= (w_next == ST_ADJ_MIN);
            blink_sec <= (w_next == ST_ADJ_SEC);
            // Field or mode change restarts the fast-adjust hold-off
            if ((w_next != r_state) || !w_in_adj) begin
                r_hold <= '0;
            end else if (tick_2hz && (r_hold != c_hold_max)) begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    assign state_o = r_state;

`ifdef STOPWATCH_CTRL_LAP_EN
    logic r_lap_d;
    logic w_lap_rise;
    logic w_enter_adj;

    assign w_lap_rise  = lap_btn & ~r_lap_d;
    assign w_enter_adj = ((w_next == ST_ADJ_MIN) || (w_next == ST_ADJ_SEC)) && !w_in_adj;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lap_d   <= 1'b0;
            disp_hold <= 1'b0;
        end else begin
            r_lap_d <= lap_btn;
            if ((w_next == ST_CLEAR) || w_enter_adj) begin
                disp_hold <= 1'b0;
            end else if ((r_state == ST_RUN) && w_lap_rise) begin
                disp_hold <= ~disp_hold;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_stopwatch_ctrl                                                 |
// | Brief  : Vector table, directed adjust/reset sequences and random stimulus |
// |          against a rule-level reference model of stopwatch_ctrl.           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_stopwatch_ctrl;

    localparam int SYNC_STAGES    = 2;
    localparam int ADJ_HOLD_TICKS = 4;
    localparam int M_RUN = 0, M_PAUSED = 1, M_ADJ_MIN = 2, M_ADJ_SEC = 3, M_CLEAR = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0, tick_2hz = 1'b0;
    logic       pause_btn = 1'b0, clear_btn = 1'b0;
    logic       sel = 1'b0, adj = 1'b0, sec_wrap = 1'b0;
    logic       sec_inc, min_inc, cnt_clr, blink_min, blink_sec, running;
    logic [2:0] state_o;
`ifdef STOPWATCH_CTRL_LAP_EN
    logic       lap_btn = 1'b0;
    logic       disp_hold;
`endif

    stopwatch_ctrl #(
        .SYNC_STAGES   (SYNC_STAGES),
        .ADJ_HOLD_TICKS(ADJ_HOLD_TICKS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .tick_2hz (tick_2hz),
        .pause_btn(pause_btn),
        .clear_btn(clear_btn),
        .sel      (sel),
        .adj      (adj),
        .sec_wrap (sec_wrap),
`ifdef STOPWATCH_CTRL_LAP_EN
        .lap_btn  (lap_btn),
        .disp_hold(disp_hold),
`endif
        .sec_inc  (sec_inc),
        .min_inc  (min_inc),
        .cnt_clr  (cnt_clr),
        .blink_min(blink_min),
        .blink_sec(blink_sec),
        .running  (running),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int n_sec       = 0;
    int n_min       = 0;

    // Reference model: mode number, hold count, last strobes, switch history
    int m_mode;
    int m_hold;
    bit m_sec, m_min;
    bit m_sel_q[$];
    bit m_adj_q[$];
    bit m_prev_pause, m_prev_clear;

    typedef struct {
        bit          t1, t2, p, c, s, a, w;
        logic [8:0]  exp;
        string       name;
    } vec_t;
    vec_t tbl[$];

    // Packed as {sec_inc, min_inc, cnt_clr, running, blink_min, blink_sec, state[2:0]}
    function automatic logic [8:0] ex(input bit si, input bit mi, input int st);
        logic [2:0] s3 = 3'(st);
        return {si, mi, st == M_CLEAR, st == M_RUN, st == M_ADJ_MIN, st == M_ADJ_SEC, s3};
    endfunction

    function automatic logic [8:0] pack_dut();
        return {sec_inc, min_inc, cnt_clr, running, blink_min, blink_sec, state_o};
    endfunction

    task automatic model_reset();
        m_mode = M_PAUSED;
        m_hold = 0;
        m_sec  = 1'b0;
        m_min  = 1'b0;
        m_sel_q.delete();
        m_adj_q.delete();
        for (int i = 0; i < SYNC_STAGES; i++) begin
            m_sel_q.push_back(1'b0);
            m_adj_q.push_back(1'b0);
        end
        m_prev_pause = 1'b0;
        m_prev_clear = 1'b0;
    endtask

    task automatic model_step();
        bit sel_s, adj_s, p_rise, c_rise, busy;
        int nxt, target;
        sel_s = m_sel_q.pop_front();
        m_sel_q.push_back(sel);
        adj_s = m_adj_q.pop_front();
        m_adj_q.push_back(adj);
        p_rise = pause_btn && !m_prev_pause;
        c_rise = clear_btn && !m_prev_clear;
        m_prev_pause = pause_btn;
        m_prev_clear = clear_btn;
        busy   = m_sec || m_min;
        m_sec  = 1'b0;
        m_min  = 1'b0;
        nxt    = m_mode;
        target = sel_s ? M_ADJ_SEC : M_ADJ_MIN;
        if (c_rise) begin
            nxt = M_CLEAR;
        end else if (m_mode == M_CLEAR) begin
            nxt = M_PAUSED;
        end else if (m_mode == M_RUN || m_mode == M_PAUSED) begin
            if (adj_s) nxt = target;
            else if (p_rise) nxt = (m_mode == M_RUN) ? M_PAUSED : M_RUN;
            else if (m_mode == M_RUN && tick_1hz && !busy) begin
                m_sec = 1'b1;
                m_min = sec_wrap;
            end
        end else begin
            nxt = adj_s ? target : M_PAUSED;
            if (nxt == m_mode && !busy && (tick_2hz || (tick_1hz && m_hold >= ADJ_HOLD_TICKS))) begin
                if (m_mode == M_ADJ_MIN) m_min = 1'b1;
                else m_sec = 1'b1;
            end
        end
        if (nxt == m_mode && (m_mode == M_ADJ_MIN || m_mode == M_ADJ_SEC)) begin
            if (tick_2hz && m_hold < ADJ_HOLD_TICKS) m_hold = m_hold + 1;
        end else begin
            m_hold = 0;
        end
        m_mode = nxt;
    endtask

    function automatic logic [8:0] model_out();
        return ex(m_sec, m_min, m_mode);
    endfunction

    task automatic check(input string name, input logic [8:0] exp);
        logic [8:0] got = pack_dut();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: dut=%b required=%b (sec,min,clr,run,bmin,bsec,state)", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: dut=%0d required=%0d", name, got, exp);
        end
    endtask

    task automatic cycle(input bit t1, t2, p, c, s, a, w);
        @(negedge clk);
        tick_1hz  = t1;
        tick_2hz  = t2;
        pause_btn = p;
        clear_btn = c;
        sel       = s;
        adj       = a;
        sec_wrap  = w;
        @(posedge clk);
        model_step();
        #1;
        n_sec += int'(sec_inc);
        n_min += int'(min_inc);
    endtask

    task automatic cyc_chk(input bit t1, t2, p, c, s, a, w, input string name);
        cycle(t1, t2, p, c, s, a, w);
        check(name, model_out());
    endtask

    task automatic add(input bit t1, t2, p, c, s, a, w, input bit si, mi, input int st, input string name);
        vec_t v;
        v.t1 = t1; v.t2 = t2; v.p = p; v.c = c; v.s = s; v.a = a; v.w = w;
        v.exp  = ex(si, mi, st);
        v.name = name;
        tbl.push_back(v);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //   t1 t2 p  c  s  a  w   sec min state
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, M_PAUSED, "idle_paused");
        add(0, 0, 1, 0, 0, 0, 0,  0, 0, M_RUN,    "pause_to_run");
        add(0, 0, 1, 0, 0, 0, 0,  0, 0, M_RUN,    "pause_held");
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, M_RUN,    "pause_release");
        add(1, 0, 0, 0, 0, 0, 0,  1, 0, M_RUN,    "tick1_a");
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, M_RUN,    "gap_a");
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, M_RUN,    "gap_a2");
        add(1, 0, 0, 0, 0, 0, 0,  1, 0, M_RUN,    "tick1_b");
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, M_RUN,    "gap_b");
        add(1, 0, 0, 0, 0, 0, 0,  1, 0, M_RUN,    "tick1_c");
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, M_RUN,    "gap_c");
        add(1, 0, 0, 0, 0, 0, 1,  1, 1, M_RUN,    "wrap_tick");
        add(0, 0, 0, 0, 0, 0, 1,  0, 0, M_RUN,    "wrap_no_tick");
        add(1, 0, 0, 0, 0, 0, 0,  1, 0, M_RUN,    "post_wrap_tick");
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, M_RUN,    "gap_d");
        add(0, 1, 0, 0, 0, 0, 0,  0, 0, M_RUN,    "tick2_in_run");
        add(1, 0, 0, 1, 0, 0, 0,  0, 0, M_CLEAR,  "clear_with_tick");
        add(0, 0, 0, 1, 0, 0, 0,  0, 0, M_PAUSED, "clear_to_paused");
        add(1, 0, 0, 0, 0, 0, 0,  0, 0, M_PAUSED, "tick1_in_paused");
        add(0, 1, 0, 0, 0, 0, 0,  0, 0, M_PAUSED, "tick2_in_paused");
        add(0, 0, 1, 0, 0, 0, 0,  0, 0, M_RUN,    "resume");
        add(1, 0, 1, 0, 0, 0, 0,  1, 0, M_RUN,    "tick_pause_held");
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, M_RUN,    "pause_release2");
        add(1, 0, 1, 0, 0, 0, 0,  0, 0, M_PAUSED, "pause_with_tick");
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, M_PAUSED, "idle_paused2");

        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", ex(0, 0, M_PAUSED));
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            cycle(tbl[i].t1, tbl[i].t2, tbl[i].p, tbl[i].c, tbl[i].s, tbl[i].a, tbl[i].w);
            check(tbl[i].name, tbl[i].exp);
        end

        // Enter ADJ_MIN through the synchroniser
        for (int i = 0; i < SYNC_STAGES; i++) begin
            cycle(0, 0, 0, 0, 0, 1, 0);
            check("adj_sync_wait", ex(0, 0, M_PAUSED));
        end
        cycle(0, 0, 0, 0, 0, 1, 0);
        check("enter_adj_min", ex(0, 0, M_ADJ_MIN));
        n_sec = 0;
        n_min = 0;
        for (int k = 0; k < 6; k++) begin
            cyc_chk(0, 1, 0, 0, 0, 1, 0, "adj_min_tick2");
            repeat (3) cyc_chk(0, 0, 0, 0, 0, 1, 0, "adj_min_gap");
            cyc_chk(1, 0, 0, 0, 0, 1, 0, "adj_min_tick1");
            repeat (3) cyc_chk(0, 0, 0, 0, 0, 1, 0, "adj_min_gap");
        end
        check_int("adj_min_count", n_min, 9);
        check_int("adj_min_no_sec", n_sec, 0);

        // Switch field to seconds: hold-off restarts, no minute carry
        for (int i = 0; i < SYNC_STAGES; i++) begin
            cycle(0, 0, 0, 0, 1, 1, 1);
            check("sel_sync_wait", ex(0, 0, M_ADJ_MIN));
        end
        cycle(0, 0, 0, 0, 1, 1, 1);
        check("enter_adj_sec", ex(0, 0, M_ADJ_SEC));
        n_sec = 0;
        n_min = 0;
        for (int k = 0; k < 3; k++) begin
            cyc_chk(1, 0, 0, 0, 1, 1, 1, "adj_sec_tick1");
            repeat (3) cyc_chk(0, 0, 0, 0, 1, 1, 1, "adj_sec_gap");
            cyc_chk(0, 1, 0, 0, 1, 1, 1, "adj_sec_tick2");
            repeat (3) cyc_chk(0, 0, 0, 0, 1, 1, 1, "adj_sec_gap");
        end
        check_int("adj_sec_count", n_sec, 3);
        check_int("adj_sec_no_min", n_min, 0);

        // Leave adjust: lands in PAUSED and ignores ticks
        for (int i = 0; i < SYNC_STAGES; i++) cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        check("leave_adj", ex(0, 0, M_PAUSED));
        n_sec = 0;
        n_min = 0;
        for (int k = 0; k < 4; k++) begin
            cyc_chk(1, 0, 0, 0, 1, 0, 0, "post_adj_tick1");
            cyc_chk(0, 0, 0, 0, 1, 0, 0, "post_adj_gap");
            cyc_chk(0, 1, 0, 0, 1, 0, 0, "post_adj_tick2");
            cyc_chk(0, 0, 0, 0, 1, 0, 0, "post_adj_gap");
        end
        check_int("post_adj_strobes", n_sec + n_min, 0);

        // Reset in the middle of a seconds strobe
        cyc_chk(0, 0, 1, 0, 0, 0, 0, "pre_reset_run");
        cyc_chk(0, 0, 0, 0, 0, 0, 0, "pre_reset_idle");
        cycle(1, 0, 0, 0, 0, 0, 0);
        check("pre_reset_strobe", ex(1, 0, M_RUN));
        #2;
        rst = 1'b0;
        #1;
        check("reset_mid_strobe", ex(0, 0, M_PAUSED));
        model_reset();
        @(negedge clk);
        tick_1hz = 1'b0;
        @(negedge clk);
        check("reset_held", ex(0, 0, M_PAUSED));
        rst = 1'b1;
        n_sec = 0;
        n_min = 0;
        for (int k = 0; k < 2; k++) begin
            cyc_chk(1, 0, 0, 0, 0, 0, 0, "post_reset_tick1");
            repeat (3) cyc_chk(0, 0, 0, 0, 0, 0, 0, "post_reset_gap");
        end
        check_int("post_reset_strobes", n_sec + n_min, 0);

        // Random stimulus against the model
        begin
            bit p_r, c_r, s_r, a_r;
            p_r = 1'b0; c_r = 1'b0; s_r = 1'b0; a_r = 1'b0;
            for (int n = 0; n < 4000; n++) begin
                if ($urandom_range(9) == 0)  p_r = ~p_r;
                if ($urandom_range(39) == 0) c_r = ~c_r;
                if ($urandom_range(29) == 0) s_r = ~s_r;
                if ($urandom_range(39) == 0) a_r = ~a_r;
                cyc_chk($urandom_range(5) == 0, $urandom_range(4) == 0, p_r, c_r, s_r, a_r,
                        $urandom_range(1) == 1, "random");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Mode and sequencing controller for the stopwatch time counter.
- Inputs: debounced pause and clear requests, the sel/adj switches, and the 1 Hz and 2 Hz tick strobes from the clock divider.
- Outputs: the single-cycle increment and clear strobes that drive the BCD minute/second counter, plus blink-field selects for the display scanner.
- Sits between clk_divider/debouncer and the counter and display mux; owns all run, pause and adjust policy.

Parameters:
- SYNC_STAGES, 2, flip-flop stages used to synchronise the asynchronous sel and adj switches (legal values 2–3).
- ADJ_HOLD_TICKS, 4, consecutive 2 Hz ticks that must pass in adjust mode before fast-adjust begins.

Ports:
- clk, in, 1, system clock (100 MHz board clock).
- rst, in, 1, reset, asynchronous, active-low; all state is cleared while low.
- tick_1hz, in, 1, one-clk strobe at 1 Hz.
- tick_2hz, in, 1, one-clk strobe at 2 Hz.
- pause_btn, in, 1, debounced pause level; a rising edge toggles run/pause.
- clear_btn, in, 1, debounced clear level; a rising edge requests a counter clear.
- sel, in, 1, raw switch: 0 = minutes field, 1 = seconds field.
- adj, in, 1, raw switch: 1 = adjust mode.
- sec_wrap, in, 1, from the counter; high when seconds = 59.
- sec_inc, out, 1, one-clk strobe that increments seconds.
- min_inc, out, 1, one-clk strobe that increments minutes.
- cnt_clr, out, 1, one-clk strobe that zeroes the counter.
- blink_min, out, 1, display blanks the minute digits on the blink phase.
- blink_sec, out, 1, display blanks the second digits on the blink phase.
- running, out, 1, high in state RUN.
- state_o, out, 3, state encoding (debug and LED use).

Behaviour:
- Reset (rst low): state = PAUSED; all strobe outputs 0; blink_min = 0; blink_sec = 0; running = 0; synchroniser and edge registers = 0; hold counter = 0.
- Synchronisation:
  - sel and adj pass through SYNC_STAGES flip-flops; the FSM uses only the synchronised copies (sel_s, adj_s).
  - pause_btn and clear_btn are edge-detected against a one-clk delayed copy, giving pause_rise and clear_rise.
- States: RUN=0, PAUSED=1, ADJ_MIN=2, ADJ_SEC=3, CLEAR=4.
- Transitions, in priority order:
  - clear_rise, from any state → CLEAR. CLEAR lasts exactly 1 clk with cnt_clr = 1, then goes to PAUSED.
  - adj_s = 1, from RUN or PAUSED → ADJ_MIN if sel_s = 0, else ADJ_SEC.
  - In adjust mode, sel_s changes switch between ADJ_MIN and ADJ_SEC on the next clk.
  - adj_s falling → PAUSED. Leaving adjust never auto-runs.
  - pause_rise: RUN → PAUSED and PAUSED → RUN. pause_rise is ignored in adjust states.
- RUN:
  - On tick_1hz: sec_inc = 1 on the following clk.
  - If sec_wrap = 1 on that tick, min_inc = 1 in the same clk as sec_inc. The counter handles the 59→00 roll and the 59:59→00:00 wrap.
- PAUSED: no increments; ticks are ignored.
- ADJ_MIN: each tick_2hz produces min_inc; sec_inc stays 0. blink_min = 1, blink_sec = 0.
- ADJ_SEC:
  - Each tick_2hz produces sec_inc with min_inc forced 0. There is no carry into minutes in adjust mode.
  - blink_sec = 1, blink_min = 0.
- Fast adjust:
  - The hold counter counts tick_2hz while in an adjust state and saturates at ADJ_HOLD_TICKS.
  - Once saturated, tick_1hz also produces an increment strobe.
  - If both ticks coincide in the same clk, only one strobe is issued.
  - The hold counter clears on any state change or sel_s change.
- Strobe latency: 1 clk from the tick to the strobe. Strobes are registered and never asserted 2 clks in a row.
- Simultaneous events:
  - clear_rise together with a tick: the clear wins and no inc strobe is issued that cycle.
  - pause_rise together with tick_1hz in RUN: the tick is dropped.
- Reset asserted mid-strobe: the strobe deasserts immediately (asynchronous).

Optional Feature:
- Macro: STOPWATCH_CTRL_LAP_EN.
- When defined:
  - Adds input lap_btn (debounced) and output disp_hold (1 bit).
  - In RUN, a lap_btn rising edge toggles disp_hold; counting continues underneath, and the display mux freezes its digit registers while disp_hold = 1.
  - disp_hold clears on reset, on CLEAR, and on entry to any adjust state. It holds its value across a RUN → PAUSED transition.
- When undefined: no lap_btn port, no disp_hold port, no associated logic.

Test Plan:
- Reset release, adj = 0, pause pulse, 3 tick_1hz → state RUN, exactly 3 sec_inc pulses each 1 clk wide, min_inc = 0, running = 1.
- In RUN with sec_wrap = 1 on a tick_1hz → sec_inc and min_inc both high in the same clk; the next tick with sec_wrap = 0 gives sec_inc only.
- adj = 1, sel = 0 for 6 tick_2hz → state ADJ_MIN after SYNC_STAGES+1 clks, blink_min = 1, 6 min_inc. After the 4th tick_2hz, interleaved tick_1hz add extra min_inc pulses; sec_inc = 0 throughout.
- Toggle sel to 1 while in adjust → ADJ_SEC, hold counter reset, blink_sec = 1, tick_2hz gives sec_inc with min_inc = 0 even with sec_wrap = 1. Setting adj = 0 → PAUSED, with no strobes on further ticks.
- clear_btn rising in the same clk as tick_1hz in RUN → cnt_clr high for exactly 1 clk, no sec_inc, next state PAUSED.
- Pull rst low mid-RUN, then release → all outputs 0 during reset, state PAUSED after release, and 2 tick_1hz produce no strobes.
